// File: rtl/fetch_realigner.sv
// fetch_realigner - splits 32-bit fetch blocks into up to two RVC/RVI instructions per cycle,
// stitching a 32-bit instruction that straddles two blocks via a one-halfword holding register.
module fetch_realigner #(
   parameter int unsigned VLEN  = 64,
   parameter int unsigned NSLOT = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic                  valid_i,
   input  logic [VLEN-1:0]       address_i,
   input  logic [31:0]           data_i,
   input  logic                  ready_i,
   output logic                  ready_o,
   output logic [NSLOT-1:0]      valid_o,
   output logic [NSLOT*VLEN-1:0] addr_o,
   output logic [NSLOT*32-1:0]   instr_o,
   output logic [NSLOT-1:0]      is_compressed_o,
   output logic                  serving_unaligned_o
);

   logic            unaligned_q, unaligned_d;
   logic [15:0]     held_q, held_d;
   logic [VLEN-1:0] held_addr_q, held_addr_d;

   logic [15:0]     hw0, hw1;
   logic            hw0_rvc, hw1_rvc;
   logic [VLEN-1:0] upper_addr;

   assign hw0        = data_i[15:0];
   assign hw1        = data_i[31:16];
   assign hw0_rvc    = (hw0[1:0] != 2'b11);
   assign hw1_rvc    = (hw1[1:0] != 2'b11);
   assign upper_addr = {address_i[VLEN-1:2], 2'b10};
   assign ready_o    = ready_i;

   always_comb begin
      valid_o             = '0;
      addr_o              = '0;
      instr_o             = '0;
      is_compressed_o     = '0;
      serving_unaligned_o = 1'b0;
      unaligned_d         = unaligned_q;
      held_d              = held_q;
      held_addr_d         = held_addr_q;

      if (valid_i) begin
         unaligned_d = 1'b0;
         if (unaligned_q) begin
            // low half of this block completes the held upper half of the previous one
            valid_o[0]          = 1'b1;
            instr_o[31:0]       = {hw0, held_q};
            addr_o[VLEN-1:0]    = held_addr_q;
            serving_unaligned_o = 1'b1;
            if (hw1_rvc) begin
               valid_o[1]              = 1'b1;
               instr_o[63:32]          = {16'b0, hw1};
               addr_o[2*VLEN-1:VLEN]   = upper_addr;
               is_compressed_o[1]      = 1'b1;
            end else begin
               unaligned_d = 1'b1;
               held_d      = hw1;
               held_addr_d = upper_addr;
            end
         end else if (!address_i[1]) begin
            valid_o[0]       = 1'b1;
            addr_o[VLEN-1:0] = address_i;
            if (hw0_rvc) begin
               instr_o[31:0]      = {16'b0, hw0};
               is_compressed_o[0] = 1'b1;
               if (hw1_rvc) begin
                  valid_o[1]            = 1'b1;
                  instr_o[63:32]        = {16'b0, hw1};
                  addr_o[2*VLEN-1:VLEN] = address_i + VLEN'(2);
                  is_compressed_o[1]    = 1'b1;
               end else begin
                  unaligned_d = 1'b1;
                  held_d      = hw1;
                  held_addr_d = address_i + VLEN'(2);
               end
            end else begin
               instr_o[31:0] = data_i;
            end
         end else begin
            // fetch entered mid-block: only the upper halfword belongs to the stream
            if (hw1_rvc) begin
               valid_o[0]         = 1'b1;
               instr_o[31:0]      = {16'b0, hw1};
               addr_o[VLEN-1:0]   = address_i;
               is_compressed_o[0] = 1'b1;
            end else begin
               unaligned_d = 1'b1;
               held_d      = hw1;
               held_addr_d = address_i;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         unaligned_q <= 1'b0;
         held_q      <= '0;
         held_addr_q <= '0;
      end else if (flush_i) begin
         unaligned_q <= 1'b0;
      end else if (valid_i && ready_i) begin
         unaligned_q <= unaligned_d;
         held_q      <= held_d;
         held_addr_q <= held_addr_d;
      end
   end

   a_no_offset_while_stitching: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(valid_i && unaligned_q && address_i[1]));

endmodule

// File: tb/tb_fetch_realigner.sv
// tb_fetch_realigner - directed vectors with hand-computed expectations for fetch_realigner.
module tb_fetch_realigner;

   localparam int unsigned VLEN = 64;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              flush_i;
   logic              valid_i;
   logic [VLEN-1:0]   address_i;
   logic [31:0]       data_i;
   logic              ready_i;
   logic              ready_o;
   logic [1:0]        valid_o;
   logic [2*VLEN-1:0] addr_o;
   logic [63:0]       instr_o;
   logic [1:0]        is_compressed_o;
   logic              serving_unaligned_o;

   int checks = 0;
   int errors = 0;

   fetch_realigner #(.VLEN(VLEN), .NSLOT(2)) dut (
      .clk_i               (clk_i),
      .rst_ni              (rst_ni),
      .flush_i             (flush_i),
      .valid_i             (valid_i),
      .address_i           (address_i),
      .data_i              (data_i),
      .ready_i             (ready_i),
      .ready_o             (ready_o),
      .valid_o             (valid_o),
      .addr_o              (addr_o),
      .instr_o             (instr_o),
      .is_compressed_o     (is_compressed_o),
      .serving_unaligned_o (serving_unaligned_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // inputs change on the falling edge and outputs are sampled 1ns later
   task automatic apply(input logic v, input logic [VLEN-1:0] a, input logic [31:0] d,
                        input logic r, input logic f);
      @(negedge clk_i);
      valid_i   = v;
      address_i = a;
      data_i    = d;
      ready_i   = r;
      flush_i   = f;
      #1;
   endtask

   task automatic slot0(input string tag, input logic [31:0] ins, input logic [VLEN-1:0] a,
                        input logic c, input logic su);
      check({tag, "_ins0"}, 64'(instr_o[31:0]), 64'(ins));
      check({tag, "_adr0"}, addr_o[VLEN-1:0], a);
      check({tag, "_c0"}, 64'(is_compressed_o[0]), 64'(c));
      check({tag, "_su"}, 64'(serving_unaligned_o), 64'(su));
   endtask

   task automatic slot1(input string tag, input logic [31:0] ins, input logic [VLEN-1:0] a);
      check({tag, "_ins1"}, 64'(instr_o[63:32]), 64'(ins));
      check({tag, "_adr1"}, addr_o[2*VLEN-1:VLEN], a);
      check({tag, "_c1"}, 64'(is_compressed_o[1]), 64'd1);
   endtask

   initial begin
      rst_ni    = 1'b0;
      flush_i   = 1'b0;
      valid_i   = 1'b0;
      address_i = '0;
      data_i    = '0;
      ready_i   = 1'b1;
      apply(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
      check("rst_valid", 64'(valid_o), 64'd0);
      check("rst_su", 64'(serving_unaligned_o), 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // two compressed halves
      apply(1'b1, 64'h1000, 32'h0001_4501, 1'b1, 1'b0);
      check("t1_valid", 64'(valid_o), 64'd3);
      check("t1_ready", 64'(ready_o), 64'd1);
      slot0("t1", 32'h0000_4501, 64'h1000, 1'b1, 1'b0);
      slot1("t1", 32'h0000_0001, 64'h1002);

      // aligned 32-bit
      apply(1'b1, 64'h1000, 32'h0000_0513, 1'b1, 1'b0);
      check("t2_valid", 64'(valid_o), 64'd1);
      slot0("t2", 32'h0000_0513, 64'h1000, 1'b0, 1'b0);

      // straddling 32-bit instruction
      apply(1'b1, 64'h2000, 32'h0513_4501, 1'b1, 1'b0);
      check("t3a_valid", 64'(valid_o), 64'd1);
      slot0("t3a", 32'h0000_4501, 64'h2000, 1'b1, 1'b0);
      apply(1'b1, 64'h2004, 32'h4505_0000, 1'b1, 1'b0);
      check("t3b_valid", 64'(valid_o), 64'd3);
      slot0("t3b", 32'h0000_0513, 64'h2002, 1'b0, 1'b1);
      slot1("t3b", 32'h0000_4505, 64'h2006);

      // entry at upper halfword
      apply(1'b1, 64'h3002, 32'h4505_1234, 1'b1, 1'b0);
      check("t4a_valid", 64'(valid_o), 64'd1);
      slot0("t4a", 32'h0000_4505, 64'h3002, 1'b1, 1'b0);
      apply(1'b1, 64'h3002, 32'h0513_1234, 1'b1, 1'b0);
      check("t4b_valid", 64'(valid_o), 64'd0);
      apply(1'b1, 64'h3004, 32'h0001_0000, 1'b1, 1'b0);
      check("t4c_valid", 64'(valid_o), 64'd3);
      slot0("t4c", 32'h0000_0513, 64'h3002, 1'b0, 1'b1);
      slot1("t4c", 32'h0000_0001, 64'h3006);

      // flush drops a pending halfword
      apply(1'b1, 64'h2000, 32'h0513_4501, 1'b1, 1'b0);
      apply(1'b0, 64'h0, 32'h0, 1'b1, 1'b1);
      check("t5_flush_valid", 64'(valid_o), 64'd0);
      apply(1'b1, 64'h4000, 32'h0000_0513, 1'b1, 1'b0);
      check("t5_valid", 64'(valid_o), 64'd1);
      slot0("t5", 32'h0000_0513, 64'h4000, 1'b0, 1'b0);

      // flush beats a hold created in the same cycle
      apply(1'b1, 64'h2000, 32'h0513_4501, 1'b1, 1'b1);
      check("t5b_valid", 64'(valid_o), 64'd1);
      apply(1'b1, 64'h4000, 32'h0000_0513, 1'b1, 1'b0);
      slot0("t5c", 32'h0000_0513, 64'h4000, 1'b0, 1'b0);

      // stall with held state
      apply(1'b1, 64'h2000, 32'h0513_4501, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 64'h2004, 32'h4505_0000, 1'b0, 1'b0);
         check("t6_stall_valid", 64'(valid_o), 64'd3);
         check("t6_stall_rdy", 64'(ready_o), 64'd0);
         slot0("t6_stall", 32'h0000_0513, 64'h2002, 1'b0, 1'b1);
      end
      apply(1'b1, 64'h2004, 32'h4505_0000, 1'b1, 1'b0);
      slot0("t6_go", 32'h0000_0513, 64'h2002, 1'b0, 1'b1);
      apply(1'b1, 64'h3000, 32'h0000_0513, 1'b1, 1'b0);
      slot0("t6_after", 32'h0000_0513, 64'h3000, 1'b0, 1'b0);

      // async reset mid-stitch
      apply(1'b1, 64'h2000, 32'h0513_4501, 1'b1, 1'b0);
      apply(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
      rst_ni = 1'b0;
      #1;
      check("t6_rst_valid", 64'(valid_o), 64'd0);
      valid_i   = 1'b1;
      address_i = 64'h2004;
      data_i    = 32'h4505_0000;
      #1;
      check("t6_rst_v2", 64'(valid_o), 64'd3);
      slot0("t6_rst", 32'h0000_0000, 64'h2004, 1'b1, 1'b0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // stitch across the top of the address space
      apply(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 32'h0513_0000, 1'b1, 1'b0);
      check("wrap_a_valid", 64'(valid_o), 64'd0);
      apply(1'b1, 64'h0, 32'h0001_0000, 1'b1, 1'b0);
      check("wrap_valid", 64'(valid_o), 64'd3);
      slot0("wrap", 32'h0000_0513, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1);
      slot1("wrap", 32'h0000_0001, 64'h2);

      apply(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
